// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, detects load-use hazards,
// redirects on ID-stage jumps and flushes on EX-resolved taken branches.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             idex_memr,
  input  logic [4:0]       idex_rt,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             pipe_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      pc_reg;
  logic [31:0]      inst_reg;
  logic [31:0]      pc4_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0] pc_plus4;
  logic [31:0] jtarget;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        uses_rt;
  logic        hazard;
  logic        jump;

  assign op = inst_reg[31:26];
  assign rs = inst_reg[25:21];
  assign rt = inst_reg[20:16];

  // Opcodes whose rt field is a source operand: R-type, beq, bne, sw.
  assign uses_rt = (op == 6'b000000) || (op == 6'b000100) ||
                   (op == 6'b000101) || (op == 6'b101011);

  assign hazard = valid_reg && idex_memr && (idex_rt != 5'd0) &&
                  ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));

  // A taken branch flushes the stalled instruction anyway, so it suppresses the stall.
  assign pipe_stall = hazard && !ex_branch_taken;
  assign jump       = valid_reg && (op == 6'b000010) && !pipe_stall;
  assign jtarget    = {pc4_reg[31:28], inst_reg[25:0], 2'b00};
  assign pc_plus4   = pc_reg + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      inst_reg  <= NOP_INST;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (ex_branch_taken) begin
      pc_reg    <= ex_branch_target;
      inst_reg  <= NOP_INST;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else if (pipe_stall) begin
      if (!(&cnt_reg))
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (jump) begin
      pc_reg    <= jtarget;
      inst_reg  <= NOP_INST;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_plus4;
      inst_reg  <= imem_rdata;
      pc4_reg   <= pc_plus4;
      valid_reg <= 1'b1;
    end
  end

  assign imem_addr  = pc_reg;
  assign ifid_inst  = inst_reg;
  assign ifid_pc4   = pc4_reg;
  assign ifid_valid = valid_reg;
  assign stall_cnt  = cnt_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage: stimulus pushes hand-computed expectations into
// a scoreboard queue, a monitor pops and compares them on the falling clock edge.
module tb_if_id_stage;

  typedef struct {
    int          idx;
    logic        rst;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        memr;
    logic [4:0]  rt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        stall;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        idex_memr;
  logic [4:0]  idex_rt;

  logic [31:0] imem_addr, ifid_inst, ifid_pc4;
  logic        ifid_valid, pipe_stall;
  logic [15:0] stall_cnt;

  logic [31:0] imem_addr2, ifid_inst2, ifid_pc42;
  logic        ifid_valid2, pipe_stall2;
  logic [1:0]  stall_cnt2;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  always #5 clk = ~clk;

  if_id_stage #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .idex_memr(idex_memr), .idex_rt(idex_rt), .ifid_inst(ifid_inst),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .pipe_stall(pipe_stall),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  if_id_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_rdata(imem_rdata),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .idex_memr(idex_memr), .idex_rt(idex_rt), .ifid_inst(ifid_inst2),
    .ifid_pc4(ifid_pc42), .ifid_valid(ifid_valid2), .pipe_stall(pipe_stall2),
    .stall_cnt(stall_cnt2)
  );

  localparam logic [31:0] A1    = 32'h2001_0001;  // addi $1,$0,1
  localparam logic [31:0] A2    = 32'h2002_0002;  // addi $2,$0,2
  localparam logic [31:0] A3    = 32'h2003_0003;  // addi $3,$0,3
  localparam logic [31:0] ADD   = 32'h0044_1820;  // add $3,$2,$4
  localparam logic [31:0] ADDI5 = 32'h20C5_0001;  // addi $5,$6,1
  localparam logic [31:0] JMP   = 32'h0800_0100;  // j 0x100

  task automatic v(input logic rst, input logic [31:0] rdata, input logic br,
                   input logic [31:0] tgt, input logic memr, input logic [4:0] rt,
                   input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4,
                   input logic valid, input logic stall, input logic [15:0] cnt,
                   input logic [1:0] cnt2);
    vec_t e;
    e.idx = vecs.size(); e.rst = rst; e.rdata = rdata; e.br = br; e.tgt = tgt;
    e.memr = memr; e.rt = rt; e.pc = pc; e.inst = inst; e.pc4 = pc4;
    e.valid = valid; e.stall = stall; e.cnt = cnt; e.cnt2 = cnt2;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s vec %0d got %h expected %h", name, idx, act, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; imem_rdata = '0; ex_branch_taken = 1'b0; ex_branch_target = '0;
    idex_memr = 1'b0; idex_rt = '0;
    //  rst rdata  br tgt           memr rt | pc            inst   pc4           vl st cnt c2
    v(1, A1,    0, 32'h0,        0, 0,  32'h0,        32'h0, 32'h0,        0, 0, 0, 0);
    v(0, A1,    0, 32'h0,        0, 0,  32'h0,        32'h0, 32'h0,        0, 0, 0, 0);
    v(0, A2,    0, 32'h0,        0, 0,  32'h4,        A1,    32'h4,        1, 0, 0, 0);
    v(0, ADD,   0, 32'h0,        0, 0,  32'h8,        A2,    32'h8,        1, 0, 0, 0);
    v(0, A3,    0, 32'h0,        1, 2,  32'hC,        ADD,   32'hC,        1, 1, 0, 0);
    v(0, A3,    0, 32'h0,        1, 4,  32'hC,        ADD,   32'hC,        1, 1, 1, 1);
    v(0, A3,    0, 32'h0,        1, 0,  32'hC,        ADD,   32'hC,        1, 0, 2, 2);
    v(0, ADDI5, 0, 32'h0,        0, 0,  32'h10,       A3,    32'h10,       1, 0, 2, 2);
    v(0, ADD,   0, 32'h0,        1, 5,  32'h14,       ADDI5, 32'h14,       1, 0, 2, 2);
    v(0, A1,    1, 32'h40,       1, 2,  32'h18,       ADD,   32'h18,       1, 0, 2, 2);
    v(0, A2,    0, 32'h0,        1, 2,  32'h40,       32'h0, 32'h0,        0, 0, 2, 2);
    v(0, A3,    1, 32'h1000_0004,0, 0,  32'h44,       A2,    32'h44,       1, 0, 2, 2);
    v(0, JMP,   0, 32'h0,        0, 0,  32'h1000_0004,32'h0, 32'h0,        0, 0, 2, 2);
    v(0, A1,    0, 32'h0,        0, 0,  32'h1000_0008,JMP,   32'h1000_0008,1, 0, 2, 2);
    v(0, A2,    0, 32'h0,        0, 0,  32'h1000_0400,32'h0, 32'h0,        0, 0, 2, 2);
    v(0, A3,    1, 32'hFFFF_FFFC,0, 0,  32'h1000_0404,A2,    32'h1000_0404,1, 0, 2, 2);
    v(0, ADD,   0, 32'h0,        0, 0,  32'hFFFF_FFFC,32'h0, 32'h0,        0, 0, 2, 2);
    v(0, A1,    0, 32'h0,        1, 2,  32'h0,        ADD,   32'h0,        1, 1, 2, 2);
    v(0, A1,    0, 32'h0,        1, 2,  32'h0,        ADD,   32'h0,        1, 1, 3, 3);
    v(0, A1,    0, 32'h0,        1, 2,  32'h0,        ADD,   32'h0,        1, 1, 4, 3);
    v(0, ADD,   0, 32'h0,        0, 0,  32'h0,        ADD,   32'h0,        1, 0, 5, 3);
    v(0, A1,    0, 32'h0,        1, 2,  32'h4,        ADD,   32'h4,        1, 1, 5, 3);
    v(1, A1,    0, 32'h0,        1, 2,  32'h0,        32'h0, 32'h0,        0, 0, 0, 0);
    v(0, A1,    0, 32'h0,        0, 0,  32'h0,        32'h0, 32'h0,        0, 0, 0, 0);
    v(0, A2,    0, 32'h0,        0, 0,  32'h4,        A1,    32'h4,        1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset            = vecs[i].rst;
      imem_rdata       = vecs[i].rdata;
      ex_branch_taken  = vecs[i].br;
      ex_branch_target = vecs[i].tgt;
      idex_memr        = vecs[i].memr;
      idex_rt          = vecs[i].rt;
      sb.push_back(vecs[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || popped != vecs.size()) begin
      errors++;
      $display("FAIL drain popped %0d expected %0d", popped, vecs.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        vec_t e;
        e = sb.pop_front();
        popped++;
        $display("vec %0d pc=%h inst=%h pc4=%h valid=%0b stall=%0b cnt=%0d cnt2=%0d",
                 e.idx, imem_addr, ifid_inst, ifid_pc4, ifid_valid, pipe_stall,
                 stall_cnt, stall_cnt2);
        chk("imem_addr",  e.idx, imem_addr,           e.pc);
        chk("ifid_inst",  e.idx, ifid_inst,           e.inst);
        chk("ifid_pc4",   e.idx, ifid_pc4,            e.pc4);
        chk("ifid_valid", e.idx, {31'd0, ifid_valid}, {31'd0, e.valid});
        chk("pipe_stall", e.idx, {31'd0, pipe_stall}, {31'd0, e.stall});
        chk("stall_cnt",  e.idx, {16'd0, stall_cnt},  {16'd0, e.cnt});
        chk("stall_cnt2", e.idx, {30'd0, stall_cnt2}, {30'd0, e.cnt2});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout popped %0d", popped);
    $fatal(1, "timeout");
  end

endmodule
